// File: rtl/mimo_fifo_lib.sv
// mimo_fifo_lib: multi-lane FIFO, up to IN_NUM pushes and OUT_NUM pops per cycle.
// Define MIMO_FIFO_OVERWRITE_EN for overwrite-oldest mode; backpressure mode otherwise.
module mimo_fifo_lib #(
  parameter int ENT_NUM = 8,
  parameter int DATA_SIZE = 32,
  parameter int IN_NUM = 2,
  parameter int OUT_NUM = 2,
  parameter int ENT_NUM_WIDTH = $clog2(ENT_NUM),
  parameter int CNT_WIDTH = $clog2(ENT_NUM+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic [IN_NUM-1:0] in_vld,
  input  logic [IN_NUM*DATA_SIZE-1:0] in_data,
  output logic in_rdy,
  output logic [OUT_NUM-1:0] out_vld,
  output logic [OUT_NUM*DATA_SIZE-1:0] out_data,
  input  logic [$clog2(OUT_NUM+1)-1:0] pick_num,
  output logic [CNT_WIDTH-1:0] ent_cnt,
  output logic fifo_full,
  output logic fifo_empty,
  output logic ovf
);
  localparam int SW = CNT_WIDTH + 1;
  logic [DATA_SIZE-1:0] mem [ENT_NUM];
  logic [ENT_NUM_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ENT_NUM_WIDTH-1:0] wr_idx [IN_NUM];
  logic [IN_NUM-1:0] wr_en;
  logic [SW-1:0] push_num, pop_num, drop_num, cnt_sum;

  // Every sum fed here is below 2*ENT_NUM, so one conditional subtract wraps it.
  function automatic logic [ENT_NUM_WIDTH-1:0] wrap(input logic [SW-1:0] s);
    return s >= SW'(ENT_NUM) ? ENT_NUM_WIDTH'(s - SW'(ENT_NUM)) : ENT_NUM_WIDTH'(s);
  endfunction

  assign wr_en = in_vld & {IN_NUM{in_rdy}};
  assign pop_num = SW'(pick_num) > SW'(ent_cnt) ? SW'(ent_cnt) : SW'(pick_num);
  assign cnt_sum = SW'(ent_cnt) - pop_num + push_num;
  assign fifo_full = ent_cnt == CNT_WIDTH'(ENT_NUM);
  assign fifo_empty = ent_cnt == '0;

`ifdef MIMO_FIFO_OVERWRITE_EN
  assign in_rdy = 1'b1;
  assign drop_num = cnt_sum > SW'(ENT_NUM) ? cnt_sum - SW'(ENT_NUM) : '0;
  assign ovf = |drop_num;
`else
  assign in_rdy = SW'(ENT_NUM) - SW'(ent_cnt) >= SW'(IN_NUM);
  assign drop_num = '0;
  assign ovf = 1'b0;
`endif

  // Valid lanes are packed into consecutive slots in ascending lane order.
  always_comb begin
    push_num = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      wr_idx[i] = wrap(SW'(wr_ptr) + push_num);
      push_num = push_num + SW'(wr_en[i]);
    end
  end

  for (genvar k = 0; k < OUT_NUM; k++) begin : g_out
    assign out_vld[k] = SW'(ent_cnt) > SW'(k);
    assign out_data[k*DATA_SIZE +: DATA_SIZE] = mem[wrap(SW'(rd_ptr) + SW'(k))];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ent_cnt <= '0;
    end else begin
      wr_ptr <= wrap(SW'(wr_ptr) + push_num);
      rd_ptr <= wrap(SW'(rd_ptr) + pop_num + drop_num);
      ent_cnt <= CNT_WIDTH'(cnt_sum - drop_num);
    end

  always_ff @(posedge clk)
    for (int i = 0; i < IN_NUM; i++)
      if (wr_en[i]) mem[wr_idx[i]] <= in_data[i*DATA_SIZE +: DATA_SIZE];
endmodule

// File: doc/mimo_fifo_lib.md
Name: mimo_fifo_lib

Overview:
- Parametrised multi-lane successor to the single-lane FIFO library cell.
- Accepts up to IN_NUM entries and releases up to OUT_NUM entries per cycle, in strict FIFO order.
- Provides explicit occupancy and full/empty status, and compile-time selection between backpressure mode and overwrite-oldest mode.
- Used as the generic buffer between multi-issue producers and consumers in the pipeline.

Parameters:
- ENT_NUM, 8, storage depth in entries; any value ≥2, need not be a power of two.
- DATA_SIZE, 32, width of one entry in bits.
- IN_NUM, 2, number of write lanes; 1 ≤ IN_NUM ≤ ENT_NUM.
- OUT_NUM, 2, number of read lanes; 1 ≤ OUT_NUM ≤ ENT_NUM.
- ENT_NUM_WIDTH, $clog2(ENT_NUM), pointer width.
- CNT_WIDTH, $clog2(ENT_NUM+1), occupancy width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_vld  in  IN_NUM  per-lane write request; any bit pattern is legal.
- in_data  in  IN_NUM*DATA_SIZE  lane i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- in_rdy  out  1  all lanes accepted this cycle.
- out_vld  out  OUT_NUM  thermometer; bit k high when ent_cnt > k.
- out_data  out  OUT_NUM*DATA_SIZE  lane k = entry at rd_ptr+k (mod ENT_NUM).
- pick_num  in  $clog2(OUT_NUM+1)  number of entries consumed this cycle.
- ent_cnt  out  CNT_WIDTH  registered occupancy.
- fifo_full  out  1  ent_cnt == ENT_NUM.
- fifo_empty  out  1  ent_cnt == 0.
- ovf  out  1  one or more oldest entries dropped this cycle.

Behaviour:
- Reset (async, active-high):
  - wr_ptr = 0, rd_ptr = 0, ent_cnt = 0.
  - Outputs: out_vld = 0, fifo_empty = 1, fifo_full = 0, in_rdy = 1, ovf = 0.
  - Storage is not reset. out_data is don't-care while the corresponding out_vld bit is low.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Push count: push_num = popcount(in_vld & {IN_NUM{in_rdy}}).
  - Valid lanes are compacted in ascending lane order: the j-th set lane is written to (wr_ptr+j) mod ENT_NUM.
- Pop count: pop_num = min(pick_num, ent_cnt).
  - Over-requesting pops is illegal upstream but is clamped here, so the pointers can never corrupt.
- Pointers advance modulo ENT_NUM, with explicit wrap for non-power-of-two depths:
  - wr_ptr += push_num
  - rd_ptr += pop_num (+ drop_num in overwrite mode)
- Occupancy: ent_cnt_nxt = ent_cnt − pop_num + push_num − drop_num.
- Latency:
  - A pushed entry is visible on out_* the cycle after the write.
  - No same-cycle bypass from in_data to out_data, including when the FIFO is empty.
- All of out_vld, fifo_full, fifo_empty and in_rdy derive from registered ent_cnt only. Same-cycle pops never raise in_rdy.
- Simultaneous push and pop are both applied. Because pop reads occur before the write, FIFO order is preserved across wrap.
- The state machine is implicit: {EMPTY, PARTIAL, FULL} decoded from ent_cnt. There is no other control state.

Optional Feature:
- Macro: MIMO_FIFO_OVERWRITE_EN.
- Defined (overwrite mode):
  - in_rdy is tied 1 and all valid lanes are always written.
  - drop_num = max(0, ent_cnt − pop_num + push_num − ENT_NUM).
  - rd_ptr additionally advances by drop_num, discarding the oldest surviving entries; ent_cnt saturates at ENT_NUM.
  - ovf = (drop_num != 0), combinational in the push cycle.
- Undefined (backpressure mode):
  - in_rdy = (ENT_NUM − ent_cnt) ≥ IN_NUM, all-or-nothing. When in_rdy = 0, all lanes are ignored.
  - drop_num = 0 and ovf is tied 0.

Test Plan (ENT_NUM=4, IN_NUM=2, OUT_NUM=2, DATA_SIZE=8 unless stated):
- Basic push/read: after reset, in_vld=2'b11 with lanes 0xA1/0xA2 → next cycle ent_cnt=2, out_vld=2'b11, out lane0=0xA1, lane1=0xA2; pick_num=2 → next cycle fifo_empty=1.
- Lane compaction: in_vld=2'b10 with lane1=0xB7 into an empty FIFO → entry 0 = 0xB7, ent_cnt=1, out_vld=2'b01, out lane0=0xB7.
- Backpressure, macro off: ent_cnt=3, in_vld=2'b11, pick_num=1 → in_rdy=0, push dropped, next ent_cnt=2, in_rdy=1.
- Wrap with non-power-of-two depth: ENT_NUM=5, 12 cycles pushing 2 and picking 2 with an incrementing pattern → output sequence 0,1,2,…,23 in order, ent_cnt never exceeds 2 in steady state.
- Overwrite, macro on: FIFO full with 1,2,3,4; push 5,6 with pick_num=0 → ovf=1 that cycle, next contents 3,4,5,6, out lane0=3, ent_cnt=4.
- Reset mid-operation: ent_cnt=3, assert rst between clock edges → ent_cnt=0, out_vld=0, fifo_empty=1 immediately; first push after release lands at entry 0.
